// File: rtl/rv32_mc_pkg.sv
// rv32_mc_pkg: shared state, opcode and datapath-select encodings for the RV32 multi-cycle core.
package rv32_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RFUNCT = 2'b10, ALU_IFUNCT = 2'b11;
  localparam logic [1:0] WB_ALUOUT = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;
  localparam logic PCSRC_ALU = 1'b0, PCSRC_ALUOUT = 1'b1;

  function automatic state_t decode_next(input logic [6:0] op);
    return op == OP_R ? S_EXEC_R :
           op == OP_I ? S_EXEC_I :
           (op == OP_LOAD || op == OP_STORE) ? S_MEM_ADDR :
           op == OP_BRANCH ? S_BRANCH :
           op == OP_JAL ? S_JAL : S_TRAP;
  endfunction
endpackage

// File: rtl/rv32_mem_timeout.sv
// rv32_mem_timeout: saturating wait counter that flags a memory request left un-acked too long.
module rv32_mem_timeout #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (count && cnt != '1) cnt <= cnt + 1'b1;
  // MEM_TIMEOUT of zero turns the watchdog off entirely
  assign expire = (MEM_TIMEOUT != 0) && count && cnt == LAST;
endmodule

// File: rtl/rv32_multi_cycle_control.sv
// rv32_multi_cycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer over a single shared memory port.
module rv32_multi_cycle_control
  import rv32_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       ZERO,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSource,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] wb_sel,
  output logic       insn_retired,
  output logic       illegal_insn,
  output logic       bus_error,
  output logic       halted
);
  state_t state, next;
  logic in_mem, tmo, br_ok, taken;
  assign in_mem = state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR;
  assign br_ok = funct3 == F3_BEQ || funct3 == F3_BNE;
  assign taken = (funct3 == F3_BEQ && ZERO) || (funct3 == F3_BNE && !ZERO);

  // the counter is held clear outside memory states, so every access starts from zero
  rv32_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_tmo (
    .clk(clk),
    .reset(reset),
    .clear(!in_mem || mem_ready),
    .count(in_mem && !mem_ready),
    .expire(tmo)
  );

  always_ff @(posedge clk)
    if (reset) state <= S_FETCH;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      S_FETCH:           next = tmo ? S_TRAP : mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:          next = decode_next(opcode);
      S_EXEC_R, S_EXEC_I: next = S_ALU_WB;
      S_MEM_ADDR:        next = opcode == OP_LOAD ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:          next = tmo ? S_TRAP : mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:          next = tmo ? S_TRAP : mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:          next = br_ok ? S_FETCH : S_TRAP;
      S_ALU_WB, S_MEM_WB, S_JAL: next = S_FETCH;
      default:           next = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we = 1'b0;
    IorD = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCSource = PCSRC_ALU;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_B;
    ALUOp = ALU_ADD;
    RegWrite = 1'b0;
    wb_sel = WB_ALUOUT;
    insn_retired = 1'b0;
    illegal_insn = 1'b0;
    bus_error = 1'b0;
    halted = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        bus_error = tmo;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal_insn = decode_next(opcode) == S_TRAP;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_A;
        ALUOp = ALU_RFUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_IFUNCT;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        insn_retired = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD = 1'b1;
        bus_error = tmo;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        wb_sel = WB_MDR;
        insn_retired = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        IorD = 1'b1;
        mem_we = 1'b1;
        insn_retired = mem_ready;
        bus_error = tmo;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        ALUOp = ALU_SUB;
        PCWrite = taken;
        PCSource = PCSRC_ALUOUT;
        insn_retired = br_ok;
        illegal_insn = !br_ok;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        wb_sel = WB_PC;
        PCWrite = 1'b1;
        PCSource = PCSRC_ALUOUT;
        insn_retired = 1'b1;
      end
      default: halted = 1'b1;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      RegWrite = 1'b0;
      insn_retired = 1'b0;
      illegal_insn = 1'b0;
      bus_error = 1'b0;
    end
  end
endmodule

// File: tb/tb_rv32_multi_cycle_control.sv
// tb_rv32_multi_cycle_control: directed and random instructions checked against a per-instruction timing/effects model.
module tb_rv32_multi_cycle_control;
  logic clk = 1'b0, reset = 1'b1, ZERO = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, RegWrite;
  logic insn_retired, illegal_insn, bus_error, halted;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, wb_sel;
  int total = 0, bad = 0;

  rv32_multi_cycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .ZERO(ZERO),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .wb_sel(wb_sel),
    .insn_retired(insn_retired), .illegal_insn(illegal_insn), .bus_error(bus_error),
    .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // entered and left at 1 time unit after a rising edge
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #3;
    chk("rst_req", int'(mem_req), 0);
    chk("rst_en", int'(IRWrite | PCWrite | RegWrite | insn_retired | illegal_insn | bus_error), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic z,
                          input int fw, input int mw);
    bit is_alu = op == 7'b0110011 || op == 7'b0010011;
    bit is_ld = op == 7'b0000011, is_st = op == 7'b0100011;
    bit is_br = op == 7'b1100011, is_jal = op == 7'b1101111;
    bit br_ok = f3 == 3'd0 || f3 == 3'd1;
    bit taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
    bit legal = is_alu || is_ld || is_st || is_jal || (is_br && br_ok);
    int flen = 1 + fw;
    int exp_ret = flen + 1 + (is_alu ? 2 : is_ld ? 3 + mw : is_st ? 2 + mw : 1);
    int exp_ill = is_br ? flen + 2 : flen + 1;
    int exp_wbs = is_ld ? 1 : is_jal ? 2 : is_alu ? 0 : -1;
    int n = 0, acc = 0, k = 0, reqs = 0, rw = 0, pcw = 0, irw = 0, we = 0;
    int iord_bad = 0, pcs_bad = 0, wbs = -1, ret_at = 0, ill_at = 0, rets = 0, bus = 0, hbad = 0;
    bit done = 0;
    opcode = op; funct3 = f3; ZERO = z;
    while (!done && n < 64) begin
      mem_ready = (k == (acc == 0 ? fw : mw));
      #3;
      n++;
      if (PCWrite) begin
        pcw++;
        if (PCSource !== (acc != 0)) pcs_bad++;
      end
      if (mem_req) begin
        reqs++;
        if (IorD !== (acc != 0)) iord_bad++;
        if (mem_we) we++;
        if (mem_ready) begin acc++; k = 0; end
        else k++;
      end
      if (RegWrite) begin rw++; wbs = int'(wb_sel); end
      if (IRWrite) irw++;
      if (bus_error) begin bus++; done = 1; end
      if (insn_retired) begin rets++; ret_at = n; done = 1; end
      if (illegal_insn) begin ill_at = n; done = 1; end
      @(posedge clk); #1;
    end
    chk("bus_err", bus, 0);
    chk("irwrite", irw, 1);
    if (legal) begin
      chk("cycles", ret_at, exp_ret);
      chk("mem_req_cycles", reqs, flen + ((is_ld || is_st) ? 1 + mw : 0));
      chk("regwrite", rw, (is_alu || is_ld || is_jal) ? 1 : 0);
      chk("wb_sel", wbs, exp_wbs);
      chk("pcwrite", pcw, 1 + ((is_jal || (is_br && taken)) ? 1 : 0));
      chk("mem_we_cycles", we, is_st ? 1 + mw : 0);
      chk("iord", iord_bad, 0);
      chk("pcsource", pcs_bad, 0);
    end else begin
      chk("illegal_at", ill_at, exp_ill);
      chk("ill_retired", rets, 0);
      chk("ill_regwrite", rw, 0);
      chk("ill_pcwrite", pcw, 1);
      for (int i = 0; i < 20; i++) begin
        mem_ready = 1'($urandom);
        #3;
        if (!halted || mem_req || RegWrite || PCWrite || IRWrite || insn_retired || illegal_insn || bus_error)
          hbad++;
        @(posedge clk); #1;
      end
      chk("trap_hold", hbad, 0);
      do_reset();
    end
  endtask

  initial begin
    int tbad;
    logic [6:0] rop;
    logic [2:0] rf3;
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #3;
    chk("reset_req", int'(mem_req), 0);
    chk("reset_retire", int'(insn_retired), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    #3;
    chk("fetch_req", int'(mem_req), 1);
    chk("fetch_srcb", int'(ALUSrcB), 1);
    chk("fetch_halted", int'(halted), 0);
    @(posedge clk); #1;
    run_insn(7'b0110011, 3'b000, 1'b0, 0, 0);
    run_insn(7'b0000011, 3'b010, 1'b0, 0, 3);
    run_insn(7'b0100011, 3'b010, 1'b0, 1, 2);
    run_insn(7'b1100011, 3'b000, 1'b1, 0, 0);
    run_insn(7'b1100011, 3'b001, 1'b1, 0, 0);
    run_insn(7'b1101111, 3'b000, 1'b0, 0, 0);
    run_insn(7'b0010011, 3'b000, 1'b0, 0, 0);
    run_insn(7'b1100011, 3'b010, 1'b0, 0, 0);
    run_insn(7'h7F, 3'b000, 1'b0, 0, 0);
    // fetch never acknowledged: error on the 16th request cycle
    do_reset();
    opcode = 7'b0110011;
    mem_ready = 1'b0;
    tbad = 0;
    for (int i = 0; i < 15; i++) begin
      #3;
      if (bus_error || !mem_req) tbad++;
      @(posedge clk); #1;
    end
    chk("tmo_early", tbad, 0);
    #3;
    chk("tmo_bus_error", int'(bus_error), 1);
    @(posedge clk); #1;
    #3;
    chk("tmo_halted", int'(halted), 1);
    @(posedge clk); #1;
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #3;
    chk("ack_wins_err", int'(bus_error), 0);
    chk("ack_wins_ir", int'(IRWrite), 1);
    @(posedge clk); #1;
    #3;
    chk("ack_wins_halted", int'(halted), 0);
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 7);
      rf3 = 3'($urandom);
      case (kind)
        0: rop = 7'b0110011;
        1: rop = 7'b0010011;
        2: rop = 7'b0000011;
        3: rop = 7'b0100011;
        4: begin rop = 7'b1100011; rf3 = 3'($urandom_range(0, 1)); end
        5: rop = 7'b1101111;
        6: rop = 7'b1100011;
        default: rop = 7'($urandom);
      endcase
      run_insn(rop, rf3, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
